// File: rtl/base_alatch_oe_q.sv
// Registered-output queue: a head register (o_v/o_d) fed from a small circular store,
// with same-cycle bypass on empty. Define BASE_ALATCH_OE_Q_CNT_EN to expose o_cnt.
module base_alatch_oe_q #(
  parameter int width = 1,
  parameter int depth = 4,
  parameter int afull = depth - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  input  logic [0:width-1] i_d,
  output logic             i_r,
  output logic             o_v,
  output logic [0:width-1] o_d,
  input  logic             o_r,
  output logic             o_en,
  output logic             o_afull
`ifdef BASE_ALATCH_OE_Q_CNT_EN
  ,
  output logic [$clog2(depth+1)-1:0] o_cnt
`endif
);

  localparam int sdepth = depth - 1;
  localparam int pw     = (sdepth > 1) ? $clog2(sdepth) : 1;
  localparam int cw     = $clog2(depth + 1);

  typedef logic [pw-1:0] ptr_t;
  typedef logic [cw-1:0] cnt_t;

  localparam ptr_t ptr_last = ptr_t'(sdepth - 1);

  logic [0:width-1] mem [0:sdepth-1];
  ptr_t rd_q, wr_q;
  cnt_t cnt_q;
  cnt_t cnt_nxt;
  cnt_t occ;
  cnt_t occ_nxt;
  logic push, st_empty, bypass, st_wr, st_rd, o_v_nxt;

  assign occ      = {{(cw-1){1'b0}}, o_v} + cnt_q;
  assign i_r      = (occ < cnt_t'(depth)) | o_r;
  assign o_en     = o_r | ~o_v;
  assign push     = i_v & i_r;
  assign st_empty = (cnt_q == '0);
  assign bypass   = o_en & st_empty & push;
  assign st_wr    = push & ~bypass;
  assign st_rd    = o_en & ~st_empty;

  always_comb begin
    cnt_nxt = cnt_q;
    if (st_wr && !st_rd) cnt_nxt = cnt_q + cnt_t'(1);
    else if (!st_wr && st_rd) cnt_nxt = cnt_q - cnt_t'(1);
    o_v_nxt = o_en ? (~st_empty | push) : o_v;
    occ_nxt = {{(cw-1){1'b0}}, o_v_nxt} + cnt_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_v     <= 1'b0;
      o_afull <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      o_v     <= o_v_nxt;
      o_afull <= (occ_nxt >= cnt_t'(afull));
      cnt_q   <= cnt_nxt;
      if (st_rd) rd_q <= (rd_q == ptr_last) ? '0 : rd_q + ptr_t'(1);
      if (st_wr) wr_q <= (wr_q == ptr_last) ? '0 : wr_q + ptr_t'(1);
    end
  end

  // Payload storage is deliberately unreset; o_v qualifies everything downstream.
  always_ff @(posedge clk) begin
    if (st_wr) mem[wr_q] <= i_d;
    if (st_rd) o_d <= mem[rd_q];
    else if (bypass) o_d <= i_d;
  end

`ifdef BASE_ALATCH_OE_Q_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_cnt <= '0;
    else        o_cnt <= occ_nxt;
  end
`endif

endmodule

// File: tb/tb_base_alatch_oe_q.sv
// Directed bench for base_alatch_oe_q (width=8, depth=4, afull=3): bypass, fill,
// full pass-through, throttled wrap traffic and mid-stream reset.
module tb_base_alatch_oe_q;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_v, i_r, o_v, o_r, o_en, o_afull;
  logic [0:7] i_d, o_d;
`ifdef BASE_ALATCH_OE_Q_CNT_EN
  logic [2:0] o_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  base_alatch_oe_q #(.width(8), .depth(4), .afull(3)) dut (
    .clk(clk), .reset(reset),
    .i_v(i_v), .i_d(i_d), .i_r(i_r),
    .o_v(o_v), .o_d(o_d), .o_r(o_r),
    .o_en(o_en), .o_afull(o_afull)
`ifdef BASE_ALATCH_OE_Q_CNT_EN
    , .o_cnt(o_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int exp);
`ifdef BASE_ALATCH_OE_Q_CNT_EN
    check(tag, 32'(o_cnt), 32'(exp));
`endif
  endtask

  initial begin
    logic [7:0] q[$];
    int sent, popped, k;
    logic mdl_ir;

    reset = 1'b0; i_v = 1'b0; i_d = 8'h00; o_r = 1'b0;
    #12;
    check("rst_o_v", 32'(o_v), 0);
    check("rst_afull", 32'(o_afull), 0);
    check("rst_i_r", 32'(i_r), 1);
    check_cnt("rst_cnt", 0);
    @(negedge clk); reset = 1'b1;
    tick();

    // bypass on empty
    o_r = 1'b1; i_v = 1'b1; i_d = 8'hA5;
    #1;
    check("byp_en0", 32'(o_en), 1);
    check("byp_ir0", 32'(i_r), 1);
    tick();
    i_v = 1'b0;
    #1;
    check("byp_o_v", 32'(o_v), 1);
    check("byp_o_d", 32'(o_d), 32'hA5);
    check("byp_en1", 32'(o_en), 1);
    check_cnt("byp_cnt", 1);
    tick();
    check("byp_drain", 32'(o_v), 0);
    check("byp_en2", 32'(o_en), 1);

    // fill with consumer stalled
    o_r = 1'b0;
    for (k = 1; k <= 4; k++) begin
      i_v = 1'b1; i_d = 8'(k);
      tick();
      check("fill_afull", 32'(o_afull), 32'(k >= 3));
      check("fill_i_r", 32'(i_r), 32'(k < 4));
      check("fill_o_d", 32'(o_d), 1);
      check_cnt("fill_cnt", k);
    end
    i_d = 8'h09;
    tick();
    check("held_i_r", 32'(i_r), 0);
    check("held_o_d", 32'(o_d), 1);
    check_cnt("held_cnt", 4);

    // full pass-through
    i_d = 8'h05; o_r = 1'b1;
    #1;
    check("pt_i_r", 32'(i_r), 1);
    tick();
    i_v = 1'b0;
    check("pt_o_d2", 32'(o_d), 2);
    check("pt_afull", 32'(o_afull), 1);
    check_cnt("pt_cnt", 4);
    tick(); check("pt_o_d3", 32'(o_d), 3); check("pt_af3", 32'(o_afull), 1);
    tick(); check("pt_o_d4", 32'(o_d), 4); check("pt_af2", 32'(o_afull), 0);
    tick(); check("pt_o_d5", 32'(o_d), 5);
    tick(); check("pt_empty", 32'(o_v), 0);

    // throttled traffic through the wrapping store
    q.delete(); sent = 0; popped = 0;
    for (int cyc = 0; cyc < 400 && popped < 20; cyc++) begin
      i_v = (sent < 20) && ($urandom_range(0, 2) != 0);
      i_d = 8'h40 + 8'(sent);
      o_r = ($urandom_range(0, 3) != 0);
      #1;
      mdl_ir = (q.size() < 4) || o_r;
      check("wr_i_r", 32'(i_r), 32'(mdl_ir));
      check("wr_o_v", 32'(o_v), 32'(q.size() != 0));
      if (q.size() != 0 && o_r) begin
        check("wr_o_d", 32'(o_d), 32'(q[0]));
        void'(q.pop_front());
        popped++;
      end
      if (i_v && mdl_ir) begin
        q.push_back(8'h40 + 8'(sent));
        sent++;
      end
      tick();
      check("wr_afull", 32'(o_afull), 32'(q.size() >= 3));
      check_cnt("wr_cnt", q.size());
    end
    check("wr_done", 32'(popped), 20);

    // reset with three words in flight
    i_v = 1'b0; o_r = 1'b0;
    tick();
    for (k = 0; k < 3; k++) begin
      i_v = 1'b1; i_d = 8'h30 + 8'(k);
      tick();
    end
    i_v = 1'b0;
    check("mr_afull_pre", 32'(o_afull), 1);
    #2 reset = 1'b0;
    #1;
    check("mr_o_v", 32'(o_v), 0);
    check("mr_afull", 32'(o_afull), 0);
    check("mr_i_r", 32'(i_r), 1);
    check_cnt("mr_cnt", 0);
    @(negedge clk); reset = 1'b1;
    o_r = 1'b1;
    for (k = 0; k < 3; k++) begin
      tick();
      check("mr_no_stale", 32'(o_v), 0);
    end
    i_v = 1'b1; i_d = 8'h77;
    tick();
    i_v = 1'b0;
    check("mr_new_v", 32'(o_v), 1);
    check("mr_new_d", 32'(o_d), 32'h77);
    tick();
    check("mr_final", 32'(o_v), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
